// File: rtl/reg_bank_wb.sv
// Write-back register bank: 32 entries, two registered read ports with write
// forwarding, one write port, and a post-reset init walk that loads defaults.
module reg_bank_wb #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int SP_IDX  = 29,
    parameter int SP_INIT = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [31:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [4:0]        rd_addr_a,
    input  logic [4:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              ready,
    output logic              wr_dropped
);

    localparam int AW = 5;
    localparam logic [AW-1:0]     LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0]     SP_ADDR  = AW'(SP_IDX);
    localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_INIT);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_mem [NREGS];

    logic [AW-1:0]     w_wr_idx;
    logic              w_mem_we;
    logic [AW-1:0]     w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_run_wr;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    // Only the low five bits of the RegDst output select an entry.
    assign w_wr_idx = wr_addr[AW-1:0];
    assign w_run_wr = (r_state == S_RUN) && RegWrite && (w_wr_idx != '0);

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = w_wr_idx;
        w_mem_wdata = wr_data;
        if (!reset) begin
            if (r_state == S_INIT) begin
                w_mem_we    = 1'b1;
                w_mem_waddr = r_cnt;
                w_mem_wdata = (r_cnt == SP_ADDR) ? SP_VAL : '0;
            end else if (w_run_wr) begin
                w_mem_we = 1'b1;
            end
        end
    end

    // Forwarding: a same-edge write to the addressed entry wins over storage.
    always_comb begin
        w_rd_a = r_mem[rd_addr_a];
        w_rd_b = r_mem[rd_addr_b];
        if (w_run_wr && (w_wr_idx == rd_addr_a)) w_rd_a = wr_data;
        if (w_run_wr && (w_wr_idx == rd_addr_b)) w_rd_b = wr_data;
        if (rd_addr_a == '0) w_rd_a = '0;
        if (rd_addr_b == '0) w_rd_b = '0;
    end

    // Storage array carries no reset; contents survive a reset cycle.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_cnt      <= '0;
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            ready      <= 1'b0;
            wr_dropped <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    rd_data_a  <= '0;
                    rd_data_b  <= '0;
                    wr_dropped <= RegWrite;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        r_state <= S_RUN;
                        ready   <= 1'b1;
                    end
                end
                S_RUN: begin
                    rd_data_a  <= w_rd_a;
                    rd_data_b  <= w_rd_b;
                    wr_dropped <= 1'b0;
                    ready      <= 1'b1;
                end
                default: begin
                    r_state <= S_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb: init walk, read/write, forwarding, $zero,
// upper address bits, writes during init and reset from RUN.
module tb_reg_bank_wb;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        ready;
    logic        wr_dropped;

    int n_checks = 0;
    int n_errors = 0;
    int n_cyc;

    reg_bank_wb dut (
        .clk        (clk),
        .reset      (reset),
        .RegWrite   (RegWrite),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .ready      (ready),
        .wr_dropped (wr_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after reset release until ready rises; bounded.
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (ready) break;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        RegWrite = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        RegWrite = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        RegWrite  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = 5'd29;
        rd_addr_b = 5'd5;

        // Init sequence
        tick();
        tick();
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_rda", rd_data_a, 32'd0);
        check("rst_drop", {31'b0, wr_dropped}, 32'd0);
        reset = 1'b0;
        wait_ready(n_cyc);
        check("init_len", n_cyc, 32'd32);
        check("init_rda_held", rd_data_a, 32'd0);
        tick();
        check("init_sp", rd_data_a, 32'd227);
        check("init_r5", rd_data_b, 32'd0);
        check("run_drop", {31'b0, wr_dropped}, 32'd0);

        // Basic write then read
        do_write(32'd8, 32'hDEADBEEF);
        rd_addr_a = 5'd8;
        tick();
        check("wr_rd8", rd_data_a, 32'hDEADBEEF);

        // Forwarding on both ports, then stored value
        rd_addr_a = 5'd12;
        rd_addr_b = 5'd12;
        do_write(32'd12, 32'h1234);
        check("fwd_a", rd_data_a, 32'h1234);
        check("fwd_b", rd_data_b, 32'h1234);
        tick();
        check("stored12", rd_data_a, 32'h1234);

        // Forwarding must show the new value, not the old one
        rd_addr_a = 5'd8;
        do_write(32'd8, 32'h0000_0055);
        check("fwd_new8", rd_data_a, 32'h55);

        // $zero register
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd0;
        do_write(32'd0, 32'hFFFF_FFFF);
        check("zero_fwd_a", rd_data_a, 32'd0);
        check("zero_fwd_b", rd_data_b, 32'd0);
        check("zero_drop", {31'b0, wr_dropped}, 32'd0);
        tick();
        check("zero_rd", rd_data_a, 32'd0);

        // Upper address bits ignored
        rd_addr_a = 5'd3;
        rd_addr_b = 5'd8;
        do_write(32'h0000_0043, 32'd5);
        tick();
        check("upper43", rd_data_a, 32'd5);
        check("r8_kept", rd_data_b, 32'h55);
        do_write(32'hFFFF_FFE3, 32'd7);
        tick();
        check("upperE3", rd_data_a, 32'd7);

        // Write during init is dropped
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        rd_addr_a = 5'd29;
        repeat (10) tick();
        RegWrite = 1'b1;
        wr_addr  = 32'd4;
        wr_data  = 32'd9;
        tick();
        RegWrite = 1'b0;
        check("init_drop_hi", {31'b0, wr_dropped}, 32'd1);
        check("init_rd_zero", rd_data_a, 32'd0);
        tick();
        check("init_drop_lo", {31'b0, wr_dropped}, 32'd0);
        wait_ready(n_cyc);
        check("init2_len", n_cyc, 32'd20);
        rd_addr_a = 5'd4;
        tick();
        check("r4_after_drop", rd_data_a, 32'd0);

        // Reset from RUN restarts init
        do_write(32'd6, 32'd77);
        rd_addr_a = 5'd6;
        rd_addr_b = 5'd29;
        tick();
        check("r6_pre", rd_data_a, 32'd77);
        reset = 1'b1;
        tick();
        check("mid_rst_ready", {31'b0, ready}, 32'd0);
        check("mid_rst_rda", rd_data_a, 32'd0);
        reset = 1'b0;
        wait_ready(n_cyc);
        check("init3_len", n_cyc, 32'd32);
        tick();
        check("r6_post", rd_data_a, 32'd0);
        check("sp_post", rd_data_b, 32'd227);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
